alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that turns a fetched RV32I instruction plus register-file read data into the operand/control bundle consumed by the ALU (`a`, `b`, `alu_ctrl`) in the execute stage. It sits between fetch/register-read and execute and owns the ALU control encoding on the producing side. It forms the ID/EX pipeline register, with stall, flush and bubble handling and illegal-instruction flagging.

## Interface
Parameters: none; datapath fixed at 32 bits.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `instr`/`pc`/`rs1_data`/`rs2_data` hold a real instruction this cycle
- `instr`  in  32  raw instruction word
- `pc`  in  32  address of `instr`
- `rs1_data`  in  32  register-file read of `instr[19:15]` (same cycle)
- `rs2_data`  in  32  register-file read of `instr[24:20]` (same cycle)
- `stall`  in  1  execute not accepting; hold outputs
- `flush`  in  1  kill the instruction being captured; insert a bubble
- `in_ready`  out  1  `~stall`, combinational
- `ex_valid`  out  1  output bundle is a real instruction
- `ex_a`, `ex_b`  out  32 each  ALU operands
- `ex_alu_ctrl`  out  4  ALU operation code
- `ex_rs2_data`  out  32  store data
- `ex_rd`  out  5  destination register
- `ex_reg_write`  out  1  writeback enable
- `ex_is_load`, `ex_is_store`, `ex_is_branch`, `ex_is_jump`  out  1 each  class flags
- `ex_funct3`  out  3  `instr[14:12]`, passed through for memory/branch
- `ex_illegal`  out  1  instruction not decodable

## Operation
- ALU codes: ADD=0010, SUB=0110, AND=0000, OR=0001, XOR=0100, SLL=1000, SRL=1001, SRA=1010, SLT=0111, SLTU=1011.
- OP (0110011): `a=rs1`, `b=rs2`. funct7=0000000 selects by funct3 {000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND}. funct7=0100000 is legal only for funct3 000 (SUB) and 101 (SRA). Any other funct7 is illegal.
- OP-IMM (0010011): `a=rs1`, `b=sext(instr[31:20])`, same funct3 map. ORI maps to OR, ANDI to AND. For SLLI/SRLI/SRAI, `b={27'b0, instr[24:20]}`. SLLI needs `instr[31:25]`=0000000. funct3 101 needs 0000000 (SRL) or 0100000 (SRA). Anything else is illegal.
- LUI: `a=0`, `b={instr[31:12],12'b0}`, ADD. AUIPC: `a=pc`, same `b`, ADD.
- LOAD (0000011) / STORE (0100011): `a=rs1`, `b`=sign-extended I- or S-immediate, ADD. LOAD sets `reg_write`; STORE clears it.
- BRANCH (1100011): `a=rs1`, `b=rs2`. funct3 000/001 use SUB, 100/101 use SLT, 110/111 use SLTU. funct3 010/011 are illegal. `reg_write`=0.
- JAL (1101111) / JALR (1100111, funct3 must be 000): `a=pc`, `b=4`, ADD (link value). `is_jump`=1.
- `ex_reg_write` is forced to 0 when rd=0, for any illegal instruction, or when `ex_valid`=0.
- Illegal (unknown opcode or illegal field): `ex_valid`=1, `ex_illegal`=1, `ex_a`=`ex_b`=0, `ex_alu_ctrl`=0010, all class flags 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `ex_*` after edge N.
- Update priority per edge: reset > flush > stall > capture.
  - Flush: `ex_valid`=0 and all control flags 0. Operand registers are don't-care but are cleared to 0. Flush wins over a simultaneous stall.
  - Stall (no flush): every `ex_*` holds its value.
  - Capture with `in_valid`=0: bubble, same as flush.
- Reset (async assert; deassert is synchronized externally): every output register is 0, including `ex_alu_ctrl`=0000 and `ex_valid`=0. A reset mid-stall discards the held instruction.
- `in_ready` is purely combinational from `stall`. There is no other combinational input-to-output path.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle `ex_a`=5, `ex_b`=7, ctrl=0010, rd=3, `reg_write`=1, `valid`=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → ctrl=1010, `ex_b`=4, rd=5. Same word with bit30=0 → ctrl=1001. With funct7=0100001 → `ex_illegal`=1, `reg_write`=0.
- BLTU x1,x2 (funct3=110) → ctrl=1011, `is_branch`=1, `reg_write`=0. LUI x7,0xABCDE → `ex_a`=0, `ex_b`=0xABCDE000, ctrl=0010.
- Capture ADD, then assert `stall` for 3 cycles while changing inputs → outputs unchanged. Assert `stall`+`flush` together → `ex_valid`=0 on the next edge.
- ADDI x0,x0,1 → `valid`=1, `reg_write`=0. Opcode 0x7F → `ex_illegal`=1, `ex_a`=`ex_b`=0.
- Pull `rst_n` low mid-cycle while holding a stalled instruction → all outputs go to 0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// This module is the RV32I decode stage and the ID/EX pipeline register. It
// decodes a fetched instruction and its register-file read data into the
// operand and control bundle that the execute stage passes to the ALU. It
// also flags illegal encodings and handles stall, flush and bubble insertion.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid                instr/pc/rs*_data carry a real instruction
//   instr, pc               raw instruction word and its address
//   rs1_data, rs2_data      register-file reads for instr[19:15]/instr[24:20]
//   stall                   execute not accepting; hold the ex_* bundle
//   flush                   kill the instruction being captured (bubble)
//   in_ready                ~stall, purely combinational
//   ex_valid, ex_illegal    bundle holds a real / undecodable instruction
//   ex_a, ex_b, ex_alu_ctrl ALU operands and operation code
//   ex_rs2_data             store data
//   ex_rd, ex_reg_write     destination register and writeback enable
//   ex_is_load/store/branch/jump  instruction class flags
//   ex_funct3               instr[14:12] for memory/branch units
// ---------------------------------------------------------------------------
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        stall,
    input  logic        flush,
    output logic        in_ready,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_rs2_data,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_is_branch,
    output logic        ex_is_jump,
    output logic [2:0]  ex_funct3,
    output logic        ex_illegal
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLTU = 4'b1011
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu_ctrl;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic [2:0]  funct3;
    } ex_bundle_t;

    // Shared funct3 -> ALU map for OP (funct7=0) and the non-shift OP-IMM ops.
    function automatic alu_op_e funct3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  funct3_op = ALU_ADD;
            3'b001:  funct3_op = ALU_SLL;
            3'b010:  funct3_op = ALU_SLT;
            3'b011:  funct3_op = ALU_SLTU;
            3'b100:  funct3_op = ALU_XOR;
            3'b101:  funct3_op = ALU_SRL;
            3'b110:  funct3_op = ALU_OR;
            default: funct3_op = ALU_AND;
        endcase
    endfunction

    // Instruction fields and immediates
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    // The rs1 index is consumed by the register file upstream; only its
    // data reaches this stage.
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    // Combinational decode
    logic [31:0] a_d;
    logic [31:0] b_d;
    alu_op_e     ctrl_d;
    logic        writes_rd;
    logic        load_d;
    logic        store_d;
    logic        branch_d;
    logic        jump_d;
    logic        illegal_d;
    ex_bundle_t  dec_d;

    always_comb begin
        a_d       = rs1_data;
        b_d       = rs2_data;
        ctrl_d    = ALU_ADD;
        writes_rd = 1'b0;
        load_d    = 1'b0;
        store_d   = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 1'b0;
        illegal_d = 1'b0;

        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == 7'b0000000) begin
                    ctrl_d = funct3_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    ctrl_d = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    ctrl_d = ALU_SRA;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OPC_OPIMM: begin
                writes_rd = 1'b1;
                b_d       = imm_i;
                case (funct3)
                    3'b001: begin
                        b_d    = shamt;
                        ctrl_d = ALU_SLL;
                        if (funct7 != 7'b0000000) illegal_d = 1'b1;
                    end
                    3'b101: begin
                        b_d = shamt;
                        if (funct7 == 7'b0000000)      ctrl_d = ALU_SRL;
                        else if (funct7 == 7'b0100000) ctrl_d = ALU_SRA;
                        else                           illegal_d = 1'b1;
                    end
                    default: ctrl_d = funct3_op(funct3);
                endcase
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                a_d       = '0;
                b_d       = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                a_d       = pc;
                b_d       = imm_u;
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                load_d    = 1'b1;
                b_d       = imm_i;
            end
            OPC_STORE: begin
                store_d = 1'b1;
                b_d     = imm_s;
            end
            OPC_BRANCH: begin
                branch_d = 1'b1;
                case (funct3)
                    3'b000, 3'b001: ctrl_d = ALU_SUB;
                    3'b100, 3'b101: ctrl_d = ALU_SLT;
                    3'b110, 3'b111: ctrl_d = ALU_SLTU;
                    default:        illegal_d = 1'b1;
                endcase
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                jump_d    = 1'b1;
                a_d       = pc;
                b_d       = 32'd4;
            end
            OPC_JALR: begin
                writes_rd = 1'b1;
                jump_d    = 1'b1;
                a_d       = pc;
                b_d       = 32'd4;
                if (funct3 != 3'b000) illegal_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal instructions still travel down the pipe (for trapping) but
        // carry no operands and no side effects.
        if (illegal_d) begin
            a_d       = '0;
            b_d       = '0;
            ctrl_d    = ALU_ADD;
            writes_rd = 1'b0;
            load_d    = 1'b0;
            store_d   = 1'b0;
            branch_d  = 1'b0;
            jump_d    = 1'b0;
        end

        dec_d           = '0;
        dec_d.valid     = 1'b1;
        dec_d.illegal   = illegal_d;
        dec_d.a         = a_d;
        dec_d.b         = b_d;
        dec_d.alu_ctrl  = ctrl_d;
        dec_d.rs2_data  = rs2_data;
        dec_d.rd        = rd;
        dec_d.reg_write = writes_rd && (rd != 5'd0);
        dec_d.is_load   = load_d;
        dec_d.is_store  = store_d;
        dec_d.is_branch = branch_d;
        dec_d.is_jump   = jump_d;
        dec_d.funct3    = funct3;
    end

    // ID/EX register: reset > flush > stall > capture (in_valid=0 -> bubble)
    ex_bundle_t ex_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= dec_d;
        end
    end

    assign in_ready     = ~stall;
    assign ex_valid     = ex_q.valid;
    assign ex_illegal   = ex_q.illegal;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_is_store  = ex_q.is_store;
    assign ex_is_branch = ex_q.is_branch;
    assign ex_is_jump   = ex_q.is_jump;
    assign ex_funct3    = ex_q.funct3;

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Self-checking bench for alu_decode_stage. Instructions are generated from a
// mnemonic-level description (kind + operation), and the expected bundle is
// derived from the mnemonic's meaning. Pipeline behaviour (stall, flush,
// bubble) is tracked with a one-entry expected-register model.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic        br;
        logic        jp;
        logic [2:0]  f3;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_is_load;
    logic        ex_is_store;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    int n_checks = 0;
    int n_fails  = 0;

    alu_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .instr        (instr),
        .pc           (pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .flush        (flush),
        .in_ready     (in_ready),
        .ex_valid     (ex_valid),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alu_ctrl  (ex_alu_ctrl),
        .ex_rs2_data  (ex_rs2_data),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_is_branch (ex_is_branch),
        .ex_is_jump   (ex_is_jump),
        .ex_funct3    (ex_funct3),
        .ex_illegal   (ex_illegal)
    );

    always #5 clk = ~clk;

    bundle_t act;
    always_comb begin
        act       = '0;
        act.valid = ex_valid;
        act.illegal = ex_illegal;
        act.a     = ex_a;
        act.b     = ex_b;
        act.ctrl  = ex_alu_ctrl;
        act.rs2   = ex_rs2_data;
        act.rd    = ex_rd;
        act.rw    = ex_reg_write;
        act.ld    = ex_is_load;
        act.st    = ex_is_store;
        act.br    = ex_is_branch;
        act.jp    = ex_is_jump;
        act.f3    = ex_funct3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fields a bubble defines: valid, all flags and the operands.
    function automatic bundle_t bubble_mask();
        bundle_t m;
        m         = '0;
        m.valid   = 1'b1;
        m.illegal = 1'b1;
        m.a       = '1;
        m.b       = '1;
        m.rw      = 1'b1;
        m.ld      = 1'b1;
        m.st      = 1'b1;
        m.br      = 1'b1;
        m.jp      = 1'b1;
        return m;
    endfunction

    // Reference model. kind: 0 R-type, 1 I-arith, 2 shift-imm, 3 LUI, 4 AUIPC,
    // 5 LOAD, 6 STORE, 7 BRANCH, 8 JAL, 9 JALR, other: illegal encoding.
    function automatic void gen_instr(input int kind, input logic [31:0] pcv,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      output logic [31:0] ins, output bundle_t e,
                                      output bundle_t m);
        logic [4:0]  rd;
        logic [4:0]  s1;
        logic [4:0]  s2;
        int          imm;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [4:0]  sh;
        int          sub;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic        wr;
        rd  = 5'($urandom);
        s1  = 5'($urandom);
        s2  = 5'($urandom);
        imm = int'($urandom_range(4095, 0)) - 2048;
        i12 = imm[11:0];
        u20 = 20'($urandom);
        sh  = 5'($urandom);
        f7  = '0;
        f3  = '0;
        opc = '0;
        wr  = 1'b0;
        ins = '0;
        e = '0;
        m = '1;
        e.valid = 1'b1;
        e.ctrl  = 4'b0010;
        e.rs2   = r2;
        e.a     = r1;
        case (kind)
            0: begin
                sub = int'($urandom_range(9, 0));
                case (sub)
                    0: begin f7 = 7'h00; f3 = 3'd0; e.ctrl = 4'b0010; end // ADD
                    1: begin f7 = 7'h20; f3 = 3'd0; e.ctrl = 4'b0110; end // SUB
                    2: begin f7 = 7'h00; f3 = 3'd1; e.ctrl = 4'b1000; end // SLL
                    3: begin f7 = 7'h00; f3 = 3'd2; e.ctrl = 4'b0111; end // SLT
                    4: begin f7 = 7'h00; f3 = 3'd3; e.ctrl = 4'b1011; end // SLTU
                    5: begin f7 = 7'h00; f3 = 3'd4; e.ctrl = 4'b0100; end // XOR
                    6: begin f7 = 7'h00; f3 = 3'd5; e.ctrl = 4'b1001; end // SRL
                    7: begin f7 = 7'h20; f3 = 3'd5; e.ctrl = 4'b1010; end // SRA
                    8: begin f7 = 7'h00; f3 = 3'd6; e.ctrl = 4'b0001; end // OR
                    default: begin f7 = 7'h00; f3 = 3'd7; e.ctrl = 4'b0000; end // AND
                endcase
                ins = {f7, s2, s1, f3, rd, 7'h33};
                e.b = r2;
                wr  = 1'b1;
            end
            1: begin
                sub = int'($urandom_range(5, 0));
                case (sub)
                    0: begin f3 = 3'd0; e.ctrl = 4'b0010; end // ADDI
                    1: begin f3 = 3'd2; e.ctrl = 4'b0111; end // SLTI
                    2: begin f3 = 3'd3; e.ctrl = 4'b1011; end // SLTIU
                    3: begin f3 = 3'd4; e.ctrl = 4'b0100; end // XORI
                    4: begin f3 = 3'd6; e.ctrl = 4'b0001; end // ORI
                    default: begin f3 = 3'd7; e.ctrl = 4'b0000; end // ANDI
                endcase
                ins = {i12, s1, f3, rd, 7'h13};
                e.b = imm;
                wr  = 1'b1;
            end
            2: begin
                sub = int'($urandom_range(2, 0));
                case (sub)
                    0: begin f7 = 7'h00; f3 = 3'd1; e.ctrl = 4'b1000; end // SLLI
                    1: begin f7 = 7'h00; f3 = 3'd5; e.ctrl = 4'b1001; end // SRLI
                    default: begin f7 = 7'h20; f3 = 3'd5; e.ctrl = 4'b1010; end // SRAI
                endcase
                ins = {f7, sh, s1, f3, rd, 7'h13};
                e.b = 32'(sh);
                wr  = 1'b1;
            end
            3, 4: begin
                ins = {u20, rd, (kind == 3) ? 7'h37 : 7'h17};
                e.a = (kind == 3) ? 32'd0 : pcv;
                e.b = 32'(u20) << 12;
                wr  = 1'b1;
            end
            5: begin
                sub = int'($urandom_range(4, 0));
                case (sub)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                ins  = {i12, s1, f3, rd, 7'h03};
                e.b  = imm;
                e.ld = 1'b1;
                wr   = 1'b1;
            end
            6: begin
                f3   = 3'($urandom_range(2, 0));
                ins  = {i12[11:5], s2, s1, f3, i12[4:0], 7'h23};
                e.b  = imm;
                e.st = 1'b1;
                m.rd = '0;
            end
            7: begin
                sub = int'($urandom_range(5, 0));
                case (sub)
                    0: begin f3 = 3'd0; e.ctrl = 4'b0110; end // BEQ
                    1: begin f3 = 3'd1; e.ctrl = 4'b0110; end // BNE
                    2: begin f3 = 3'd4; e.ctrl = 4'b0111; end // BLT
                    3: begin f3 = 3'd5; e.ctrl = 4'b0111; end // BGE
                    4: begin f3 = 3'd6; e.ctrl = 4'b1011; end // BLTU
                    default: begin f3 = 3'd7; e.ctrl = 4'b1011; end // BGEU
                endcase
                ins  = {7'($urandom), s2, s1, f3, 5'($urandom), 7'h63};
                e.b  = r2;
                e.br = 1'b1;
                m.rd = '0;
            end
            8: begin
                ins  = {u20, rd, 7'h6F};
                e.a  = pcv;
                e.b  = 32'd4;
                e.jp = 1'b1;
                wr   = 1'b1;
            end
            9: begin
                ins  = {i12, s1, 3'b000, rd, 7'h67};
                e.a  = pcv;
                e.b  = 32'd4;
                e.jp = 1'b1;
                wr   = 1'b1;
            end
            default: begin
                sub = int'($urandom_range(4, 0));
                case (sub)
                    0: begin
                        do opc = 7'($urandom);
                        while (opc inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03,
                                           7'h23, 7'h63, 7'h6F, 7'h67});
                        ins = {25'($urandom), opc};
                    end
                    1: begin
                        if ($urandom_range(1, 0) == 0) begin
                            f3 = 3'($urandom);
                            do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        end else begin
                            f7 = 7'h20;
                            do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd5);
                        end
                        ins = {f7, s2, s1, f3, rd, 7'h33};
                    end
                    2: begin
                        if ($urandom_range(1, 0) == 0) begin
                            f3 = 3'd1;
                            do f7 = 7'($urandom); while (f7 == 7'h00);
                        end else begin
                            f3 = 3'd5;
                            do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        end
                        ins = {f7, sh, s1, f3, rd, 7'h13};
                    end
                    3: ins = {7'($urandom), s2, s1, 3'b010 + 3'($urandom_range(1, 0)),
                              5'($urandom), 7'h63};
                    default: begin
                        do f3 = 3'($urandom); while (f3 == 3'd0);
                        ins = {i12, s1, f3, rd, 7'h67};
                    end
                endcase
                e.illegal = 1'b1;
                e.a       = '0;
                e.b       = '0;
                e.ctrl    = 4'b0010;
                m.rd      = '0;
                m.rs2     = '0;
                m.f3      = '0;
            end
        endcase
        e.f3 = ins[14:12];
        e.rd = rd;
        e.rw = wr && (rd != 5'd0);
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h002081B3;
        pc       = 32'h100;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        stall    = 1'b0;
        flush    = 1'b0;
        step();
        step();
        n_checks++;
        if (act !== '0) begin
            $display("FAIL reset_outputs: got %h want 0", act);
            n_fails++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
            n_fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_directed();
        bundle_t e;
        bundle_t m;
        // ADD x3,x1,x2
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; in_valid = 1'b1;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'd5; e.b = 32'd7; e.ctrl = 4'b0010;
        e.rs2 = 32'd7; e.rd = 5'd3; e.rw = 1'b1; e.f3 = 3'd0;
        n_checks++;
        if (act !== e) begin
            $display("FAIL dir_add: got %h want %h", act, e); n_fails++;
        end
        // SRAI x5,x6,4
        instr = 32'h40435293; rs1_data = 32'h80000000; rs2_data = 32'h11111111;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'h80000000; e.b = 32'd4; e.ctrl = 4'b1010;
        e.rs2 = 32'h11111111; e.rd = 5'd5; e.rw = 1'b1; e.f3 = 3'd5;
        n_checks++;
        if (act !== e) begin
            $display("FAIL dir_srai: got %h want %h", act, e); n_fails++;
        end
        // SRLI (bit30 cleared)
        instr = 32'h00435293;
        step();
        e.ctrl = 4'b1001;
        n_checks++;
        if (act !== e) begin
            $display("FAIL dir_srli: got %h want %h", act, e); n_fails++;
        end
        // shift with funct7=0100001 is illegal
        instr = 32'h42435293;
        step();
        e = '0; e.valid = 1'b1; e.illegal = 1'b1; e.ctrl = 4'b0010;
        m = '1; m.rd = '0; m.rs2 = '0; m.f3 = '0;
        n_checks++;
        if ((act & m) !== (e & m)) begin
            $display("FAIL dir_srai_bad_f7: got %h want %h", act & m, e & m); n_fails++;
        end
        // BLTU x1,x2
        instr = 32'h0020E063; rs1_data = 32'hFFFF0000; rs2_data = 32'h0000FFFF;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'hFFFF0000; e.b = 32'h0000FFFF; e.ctrl = 4'b1011;
        e.rs2 = 32'h0000FFFF; e.br = 1'b1; e.f3 = 3'd6;
        m = '1; m.rd = '0;
        n_checks++;
        if ((act & m) !== (e & m)) begin
            $display("FAIL dir_bltu: got %h want %h", act & m, e & m); n_fails++;
        end
        // LUI x7,0xABCDE
        instr = 32'hABCDE3B7; rs1_data = 32'h12345678; rs2_data = 32'd0;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'd0; e.b = 32'hABCDE000; e.ctrl = 4'b0010;
        e.rd = 5'd7; e.rw = 1'b1; e.f3 = 3'd6;
        n_checks++;
        if (act !== e) begin
            $display("FAIL dir_lui: got %h want %h", act, e); n_fails++;
        end
        // ADDI x0,x0,1 : valid but no writeback
        instr = 32'h00100013; rs1_data = 32'd0; rs2_data = 32'd9;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'd0; e.b = 32'd1; e.ctrl = 4'b0010; e.rs2 = 32'd9;
        n_checks++;
        if (act !== e) begin
            $display("FAIL dir_addi_x0: got %h want %h", act, e); n_fails++;
        end
        // Unknown opcode 0x7F
        instr = 32'h0000007F; rs1_data = 32'd3; rs2_data = 32'd9;
        step();
        e = '0; e.valid = 1'b1; e.illegal = 1'b1; e.ctrl = 4'b0010;
        m = '1; m.rd = '0; m.rs2 = '0; m.f3 = '0;
        n_checks++;
        if ((act & m) !== (e & m)) begin
            $display("FAIL dir_bad_opcode: got %h want %h", act & m, e & m); n_fails++;
        end
    endtask

    task automatic test_decode_random();
        bundle_t     e;
        bundle_t     m;
        logic [31:0] w;
        for (int i = 0; i < 300; i++) begin
            pc       = $urandom;
            rs1_data = $urandom;
            rs2_data = $urandom;
            in_valid = 1'b1;
            stall    = 1'b0;
            flush    = 1'b0;
            gen_instr(int'($urandom_range(10, 0)), pc, rs1_data, rs2_data, w, e, m);
            instr = w;
            step();
            n_checks++;
            if ((act & m) !== (e & m)) begin
                $display("FAIL decode_random[%0d] instr=%h: got %h want %h",
                         i, w, act & m, e & m);
                n_fails++;
            end
        end
    endtask

    task automatic test_stall_flush();
        bundle_t e;
        bundle_t m;
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; pc = 32'h40;
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        step();
        e = '0; e.valid = 1'b1; e.a = 32'd5; e.b = 32'd7; e.ctrl = 4'b0010;
        e.rs2 = 32'd7; e.rd = 5'd3; e.rw = 1'b1; e.f3 = 3'd0;
        n_checks++;
        if (act !== e) begin
            $display("FAIL stall_capture: got %h want %h", act, e); n_fails++;
        end
        for (int i = 0; i < 3; i++) begin
            stall    = 1'b1;
            instr    = $urandom;
            rs1_data = $urandom;
            rs2_data = $urandom;
            pc       = $urandom;
            in_valid = 1'($urandom);
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); n_fails++;
            end
            step();
            n_checks++;
            if (act !== e) begin
                $display("FAIL stall_hold[%0d]: got %h want %h", i, act, e); n_fails++;
            end
        end
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
        step();
        m = bubble_mask();
        n_checks++;
        if ((act & m) !== '0) begin
            $display("FAIL stall_flush_bubble: got %h want 0", act & m); n_fails++;
        end
        flush = 1'b0; stall = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if ((act & m) !== '0) begin
            $display("FAIL invalid_bubble: got %h want 0", act & m); n_fails++;
        end
    endtask

    task automatic test_back_to_back();
        bundle_t     e;
        bundle_t     m;
        bundle_t     held_e;
        bundle_t     held_m;
        logic [31:0] w;
        logic        st;
        logic        fl;
        logic        iv;
        flush = 1'b1; stall = 1'b0; in_valid = 1'b1;
        step();
        held_e = '0;
        held_m = bubble_mask();
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(3, 0) == 0);
            fl = ($urandom_range(9, 0) == 0);
            iv = ($urandom_range(7, 0) != 0);
            pc       = $urandom;
            rs1_data = $urandom;
            rs2_data = $urandom;
            gen_instr(int'($urandom_range(10, 0)), pc, rs1_data, rs2_data, w, e, m);
            instr    = w;
            stall    = st;
            flush    = fl;
            in_valid = iv;
            #1;
            n_checks++;
            if (in_ready !== ~st) begin
                $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, in_ready, ~st);
                n_fails++;
            end
            step();
            if (fl || (!st && !iv)) begin
                held_e = '0;
                held_m = bubble_mask();
            end else if (!st) begin
                held_e = e;
                held_m = m;
            end
            n_checks++;
            if ((act & held_m) !== (held_e & held_m)) begin
                $display("FAIL b2b[%0d] st=%b fl=%b iv=%b: got %h want %h",
                         i, st, fl, iv, act & held_m, held_e & held_m);
                n_fails++;
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        step();
        stall = 1'b1;
        step();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'd5) begin
            $display("FAIL async_pre_hold: got valid=%b a=%h want 1/00000005", ex_valid, ex_a);
            n_fails++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act !== '0) begin
            $display("FAIL async_reset: got %h want 0", act); n_fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_decode_random();
        test_stall_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
